// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and the write-back request type for the register file write arbiter.
package regfile_write_arbiter_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Execute/memory/decode side bus of the write arbiter and its register file write port.
interface regfile_write_arbiter_if;
   import regfile_write_arbiter_pkg::*;

   logic              alu_valid;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              iss_valid;
   logic [ADDR_W-1:0] iss_rd;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_rd;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic              raw_stall;
   logic              wr;
   logic [ADDR_W-1:0] Addr_Wr;
   logic [DATA_W-1:0] RESULT;

   modport master (
      output alu_valid, alu_rd, alu_data, iss_valid, iss_rd,
             mem_valid, mem_rd, mem_data, rs1, rs2,
      input  alu_ready, mem_ready, raw_stall, wr, Addr_Wr, RESULT
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, iss_valid, iss_rd,
             mem_valid, mem_rd, mem_data, rs1, rs2,
      output alu_ready, mem_ready, raw_stall, wr, Addr_Wr, RESULT
   );
endinterface

// File: rtl/regfile_write_arbiter_fifo.sv
// Synchronous FIFO buffering long-latency write-back results; head is visible while not empty.
module wb_result_fifo
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  wb_req_t push_data,
   input  logic    pop,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_req_t            mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write port owner for the register file: arbitrates ALU vs. buffered long-latency
// results and tracks outstanding long-latency destinations for decode RAW stalls.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int FIFO_DEP = 4
) (
   input logic                    clk,
   input logic                    rst,
   regfile_write_arbiter_if.slave bus
);
   localparam int NREG = 2 ** ADDR_W;

   wb_req_t           alu_req;
   wb_req_t           mem_req;
   wb_req_t           fifo_head;
   wb_req_t           sel_req;
   logic              fifo_full;
   logic              fifo_empty;
   logic              sel_fifo;
   logic              sel_alu;
   logic              sel_any;
   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   pending_next;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] result_q;

   assign alu_req = '{rd: bus.alu_rd, data: bus.alu_data};
   assign mem_req = '{rd: bus.mem_rd, data: bus.mem_data};

   wb_result_fifo #(.DEPTH(FIFO_DEP)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.mem_valid),
      .push_data (mem_req),
      .pop       (sel_fifo),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A full FIFO forces a drain so long-latency producers can never be starved by the ALU.
   always_comb begin
      sel_fifo = !fifo_empty && (fifo_full || !bus.alu_valid);
      sel_alu  = bus.alu_valid && !fifo_full;
      sel_any  = sel_fifo || sel_alu;
      sel_req  = sel_fifo ? fifo_head : alu_req;
   end

   // Issue-side set is applied after the retire-side clear so a same-cycle reissue stays pending.
   always_comb begin
      pending_next = pending;
      if (sel_fifo) pending_next[fifo_head.rd] = 1'b0;
      if (bus.iss_valid) pending_next[bus.iss_rd] = 1'b1;
      pending_next[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q     <= 1'b0;
         addr_q   <= '0;
         result_q <= '0;
         pending  <= '0;
      end else begin
         pending <= pending_next;
         if (sel_any) begin
            wr_q     <= (sel_req.rd != REG_ZERO);
            addr_q   <= sel_req.rd;
            result_q <= sel_req.data;
         end else begin
            wr_q <= 1'b0;
         end
      end
   end

   assign bus.alu_ready = !fifo_full;
   assign bus.mem_ready = !fifo_full;
   assign bus.raw_stall = pending[bus.rs1] | pending[bus.rs2];
   assign bus.wr        = wr_q;
   assign bus.Addr_Wr   = addr_q;
   assign bus.RESULT    = result_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   n_asrt = 0;
   int   n_fail = 0;

   regfile_write_arbiter_if bus ();

   regfile_write_arbiter #(.FIFO_DEP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alu_valid = 1'b0;
      bus.iss_valid = 1'b0;
      bus.mem_valid = 1'b0;
   endtask

   task automatic alu(input logic [4:0] rd, input logic [31:0] data);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = rd;
      bus.alu_data  = data;
   endtask

   task automatic mem(input logic [4:0] rd, input logic [31:0] data);
      bus.mem_valid = 1'b1;
      bus.mem_rd    = rd;
      bus.mem_data  = data;
   endtask

   task automatic iss(input logic [4:0] rd);
      bus.iss_valid = 1'b1;
      bus.iss_rd    = rd;
   endtask

   task automatic check_wr(input string tag, input logic w, input logic [4:0] a,
                           input logic [31:0] d);
      check({tag, "_wr"}, bus.wr, w);
      check({tag, "_addr"}, bus.Addr_Wr, a);
      check({tag, "_data"}, bus.RESULT, d);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      bus.alu_rd = '0; bus.alu_data = '0; bus.iss_rd = '0;
      bus.mem_rd = '0; bus.mem_data = '0; bus.rs1 = '0; bus.rs2 = '0;

      // reset
      tick(); tick();
      check_wr("reset", 1'b0, 5'd0, 32'h0);
      check("reset_alu_ready", bus.alu_ready, 1'b1);
      check("reset_mem_ready", bus.mem_ready, 1'b1);
      check("reset_raw_stall", bus.raw_stall, 1'b0);
      rst = 1'b0;

      // ALU only
      alu(5'd5, 32'hDEADBEEF);
      #1 check("alu_ready_idle", bus.alu_ready, 1'b1);
      tick(); idle();
      check_wr("alu_only", 1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      check_wr("alu_hold", 1'b0, 5'd5, 32'hDEADBEEF);

      // x0 write and x0 issue
      alu(5'd0, 32'h1234); iss(5'd0); bus.rs1 = 5'd0;
      tick(); idle();
      check_wr("x0", 1'b0, 5'd0, 32'h1234);
      check("x0_stall", bus.raw_stall, 1'b0);

      // scoreboard
      iss(5'd7); bus.rs1 = 5'd7;
      #1 check("sb_before_edge", bus.raw_stall, 1'b0);
      tick(); idle();
      check("sb_set_rs1", bus.raw_stall, 1'b1);
      bus.rs1 = 5'd0; bus.rs2 = 5'd7;
      #1 check("sb_set_rs2", bus.raw_stall, 1'b1);
      alu(5'd7, 32'h99);
      tick(); idle();
      check_wr("sb_alu_w7", 1'b1, 5'd7, 32'h99);
      check("sb_alu_noclear", bus.raw_stall, 1'b1);
      mem(5'd7, 32'h55);
      #1 check("sb_mem_ready", bus.mem_ready, 1'b1);
      tick(); idle();
      check("sb_push_wr", bus.wr, 1'b0);
      check("sb_stall_pop_cycle", bus.raw_stall, 1'b1);
      tick();
      check_wr("sb_mem_w7", 1'b1, 5'd7, 32'h55);
      check("sb_cleared", bus.raw_stall, 1'b0);

      // set wins over clear for the same rd
      iss(5'd9); bus.rs1 = 5'd9; bus.rs2 = 5'd0;
      tick(); idle();
      mem(5'd9, 32'h900);
      tick(); idle();
      iss(5'd9);
      tick(); idle();
      check_wr("setwins_w9", 1'b1, 5'd9, 32'h900);
      check("setwins_stall", bus.raw_stall, 1'b1);

      // contention: ALU busy every cycle while four mem results arrive
      for (int k = 0; k < 4; k++) begin
         alu(5'd20, 32'hA0 + k);
         mem(5'(k + 1), 32'h100 + k + 1);
         #1 check("cont_mem_ready", bus.mem_ready, 1'b1);
         tick();
         check_wr("cont_alu", 1'b1, 5'd20, 32'hA0 + k);
      end
      bus.mem_valid = 1'b0;
      alu(5'd21, 32'hB0);
      #1;
      check("full_mem_ready", bus.mem_ready, 1'b0);
      check("full_alu_ready", bus.alu_ready, 1'b0);
      tick();
      check_wr("drain_1", 1'b1, 5'd1, 32'h101);
      check("after_pop_alu_ready", bus.alu_ready, 1'b1);
      tick(); idle();
      check_wr("alu_after_pop", 1'b1, 5'd21, 32'hB0);
      tick();
      check_wr("drain_2", 1'b1, 5'd2, 32'h102);
      tick();
      check_wr("drain_3", 1'b1, 5'd3, 32'h103);
      tick();
      check_wr("drain_4", 1'b1, 5'd4, 32'h104);
      tick();
      check("drained_wr", bus.wr, 1'b0);

      // reset mid-operation with three entries queued and reg 12 pending
      iss(5'd12);
      tick(); idle();
      for (int k = 0; k < 3; k++) begin
         alu(5'd22, 32'hC0 + k);
         mem(5'(12 + k), 32'h200 + k);
         tick();
      end
      idle();
      bus.rs1 = 5'd12; bus.rs2 = 5'd9;
      #1 check("pre_rst_stall", bus.raw_stall, 1'b1);
      rst = 1'b1;
      alu(5'd23, 32'hD0);
      tick();
      check("midrst_wr", bus.wr, 1'b0);
      check("midrst_stall", bus.raw_stall, 1'b0);
      check("midrst_mem_ready", bus.mem_ready, 1'b1);
      rst = 1'b0; idle();
      tick();
      check("midrst_fifo_empty", bus.wr, 1'b0);
      tick();
      check("midrst_fifo_empty2", bus.wr, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
